photonic_channel_scheduler: RTL and testbench
=============================================

# photonic_channel_scheduler

- Round-robin scheduler that shares the single photonic data channel among `NUM_NODES` requesting nodes.
- For each winner it:
  - pulses a laser/ring tuning start;
  - waits a fixed guard time;
  - holds a one-hot grant until the data plane reports burst completion or a timeout fires.
- Sits between the per-node control planes (which raise transmit requests) and the shared data-plane transmitter/receiver.

## Interface
Parameters:
- `NUM_NODES`, 4: number of requesters; range 2..16.
- `ID_W`, 16: width of `grant_id`; matches the node-ID width used by the control plane.
- `GUARD_CYCLES`, 2: tuning/settling cycles before a grant is asserted; range 1..255.
- `TIMEOUT_CYCLES`, 64: maximum cycles a grant may be held; range 2..65535.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset is synchronous and active-low.
- `enable` in 1: when low, no new arbitration starts; an in-flight guard or grant runs to completion.
- `req` in `NUM_NODES`: level request per node; held until the node's grant ends.
- `xfer_done` in 1: one-cycle pulse from the data plane; the granted burst is complete.
- `grant` out `NUM_NODES`: one-hot grant, or all zero.
- `grant_id` out `ID_W`: index of the selected node, zero-extended; valid while `busy` is high.
- `tune_start` out 1: one-cycle pulse on entry to GUARD.
- `busy` out 1: high in GUARD, GRANT and RELEASE.
- `timeout_pulse` out 1: one-cycle pulse when a grant ends by timeout.

## Operation
- **States:** IDLE, GUARD, GRANT, RELEASE.
- **Reset values:** state IDLE, `grant`=0, `grant_id`=0, `tune_start`=0, `busy`=0, `timeout_pulse`=0, priority pointer `ptr`=0, counters=0.
- **IDLE:**
  - If `enable` is high and `req` is nonzero, select the first requesting index searching `ptr`, `ptr`+1, … modulo `NUM_NODES`.
  - Register the selection in `grant_id`, pulse `tune_start`, load the guard counter with `GUARD_CYCLES`-1, go to GUARD.
- **GUARD:**
  - Decrement the guard counter each cycle.
  - At zero, go to GRANT and assert `grant[grant_id]`.
  - If the selected node's `req` drops during GUARD: abort to IDLE, no grant, `ptr` unchanged.
- **GRANT:**
  - The timeout counter starts at 0 and increments each cycle.
  - `xfer_done` high → go to RELEASE.
  - Else counter == `TIMEOUT_CYCLES`-1 → go to RELEASE and pulse `timeout_pulse` in the RELEASE cycle.
  - `xfer_done` and timeout in the same cycle: done wins, no `timeout_pulse`.
- **RELEASE** (1 cycle):
  - `grant` = 0.
  - `ptr` = (`grant_id`+1) mod `NUM_NODES`, wrapping from `NUM_NODES`-1 to 0.
  - Next state IDLE.
- `xfer_done` outside GRANT is ignored.
- `req` changes outside IDLE do not alter the selection, except the GUARD abort above.
- `enable` falling mid-operation has no effect until the return to IDLE.
- Reset asserted in any state returns to IDLE with all reset values on the next edge; a grant in flight is dropped with no `timeout_pulse`.

## Timing
- `req` sampled high in IDLE at edge t:
  - `tune_start`=1 and `busy`=1 during cycle t+1;
  - `grant` asserted from edge t+1+`GUARD_CYCLES`.
- `xfer_done` sampled at edge u: `grant` low from edge u+1 (RELEASE); IDLE at u+2.
- Minimum grant-to-grant spacing for back-to-back requesters: 3+`GUARD_CYCLES` cycles after `xfer_done`.
- Timeout: `grant` held exactly `TIMEOUT_CYCLES` cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `comms_pkg`:
  - state enum `sched_state_t` {IDLE, GUARD, GRANT, RELEASE};
  - `NODE_ID_W`=16 constant;
  - one-hot/index helper function.
- One sub-module, `rr_priority_select`: combinational round-robin pick (`req`, `ptr` → `valid`, `index`).
- FSM, counters and output registers live in the top module.

## Test plan
- **Single requester:** `NUM_NODES`=4, `GUARD_CYCLES`=2, `req`=0b0100 at edge 10.
  - `tune_start` at cycle 11; `grant`=0b0100 and `grant_id`=2 from edge 13.
  - `xfer_done` at 20 → `grant`=0 at 21; `ptr`=3.
- **Fairness:** `req`=0b1111 held, `xfer_done` 5 cycles after each grant → grant order 0,1,2,3,0; the wrap from 3 to 0 is checked.
- **Timeout:** `TIMEOUT_CYCLES`=8, no `xfer_done` → grant held 8 cycles, one `timeout_pulse`, `ptr` advances.
- **Done/timeout collision:** `xfer_done` on the final timeout cycle → RELEASE with `timeout_pulse`=0.
- **GUARD abort:** `req` for the selected node drops mid-GUARD → no grant, back to IDLE, `ptr` unchanged. Then `enable`=0 with `req`=0b0001 → no `tune_start` until `enable`=1.
- **Reset mid-GRANT:** `rst`=0 for one edge → all outputs 0, `ptr`=0, next arbitration restarts from node 0.

Source files
------------

// File: rtl/comms_pkg.sv
// ---------------------------------------------------------------------------
// comms_pkg
// Shared definitions for the photonic channel scheduler.
//   sched_state_t  : scheduler FSM states
//   NODE_ID_W      : node-ID width used by the control plane
//   idx_to_onehot  : converts a node index (0..15) into a one-hot vector
// ---------------------------------------------------------------------------
package comms_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GUARD   = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } sched_state_t;

  localparam int NODE_ID_W = 16;
  localparam int MAX_NODES = 16;

  function automatic logic [MAX_NODES-1:0] idx_to_onehot(input logic [3:0] idx);
    return MAX_NODES'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// ---------------------------------------------------------------------------
// rr_priority_select
// Combinational round-robin pick: returns the first requesting node found
// when searching ptr, ptr+1, ... modulo NUM_NODES.
//   req   in  NUM_NODES : request vector
//   ptr   in  IDX_W     : highest-priority node index
//   valid out 1         : at least one request present
//   index out IDX_W     : selected node index
// ---------------------------------------------------------------------------
module rr_priority_select #(
  parameter int NUM_NODES = 4,
  parameter int IDX_W     = $clog2(NUM_NODES)
) (
  input  logic [NUM_NODES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 valid,
  output logic [IDX_W-1:0]     index
);

  // Scan from the farthest offset down to offset 0 so the candidate closest
  // to ptr is the one left standing.
  always_comb begin
    int pos;
    logic [IDX_W-1:0] pos_idx;
    valid   = 1'b0;
    index   = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = NUM_NODES - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_NODES) pos = pos - NUM_NODES;
      pos_idx = IDX_W'(pos);
      if (req[pos_idx]) begin
        valid = 1'b1;
        index = pos_idx;
      end
    end
  end

endmodule

// File: rtl/photonic_channel_scheduler.sv
// ---------------------------------------------------------------------------
// photonic_channel_scheduler
// Round-robin owner selection for the shared photonic data channel. A winner
// gets a tuning pulse, a guard interval, then a one-hot grant held until the
// data plane reports completion or the grant times out.
//   clk           in  1          : clock, rising edge
//   rst           in  1          : synchronous reset, active low
//   enable        in  1          : allows new arbitration from IDLE
//   req           in  NUM_NODES  : level request per node
//   xfer_done     in  1          : burst complete pulse (used in GRANT only)
//   grant         out NUM_NODES  : one-hot grant or zero
//   grant_id      out ID_W       : selected node index, zero-extended
//   tune_start    out 1          : pulse on entry to GUARD
//   busy          out 1          : high in GUARD, GRANT, RELEASE
//   timeout_pulse out 1          : pulse in RELEASE after a timeout
// All outputs are registered.
// ---------------------------------------------------------------------------
module photonic_channel_scheduler
  import comms_pkg::*;
#(
  parameter int NUM_NODES      = 4,
  parameter int ID_W           = NODE_ID_W,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_NODES-1:0] req,
  input  logic                 xfer_done,
  output logic [NUM_NODES-1:0] grant,
  output logic [ID_W-1:0]      grant_id,
  output logic                 tune_start,
  output logic                 busy,
  output logic                 timeout_pulse
);

  localparam int               IDX_W      = $clog2(NUM_NODES);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_NODES - 1);
  localparam logic [7:0]       GUARD_LOAD = 8'(GUARD_CYCLES - 1);
  localparam logic [15:0]      TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  sched_state_t         state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           guard_q, guard_d;
  logic [15:0]          tmo_q, tmo_d;
  logic [NUM_NODES-1:0] grant_q, grant_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 tune_start_q, tune_start_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;

  logic                 sel_valid;
  logic [IDX_W-1:0]     sel_index;

  rr_priority_select #(
    .NUM_NODES (NUM_NODES),
    .IDX_W     (IDX_W)
  ) u_select (
    .req   (req),
    .ptr   (ptr_q),
    .valid (sel_valid),
    .index (sel_index)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      guard_q      <= '0;
      tmo_q        <= '0;
      grant_q      <= '0;
      grant_id_q   <= '0;
      tune_start_q <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      guard_q      <= guard_d;
      tmo_q        <= tmo_d;
      grant_q      <= grant_d;
      grant_id_q   <= grant_id_d;
      tune_start_q <= tune_start_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    guard_d = guard_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (enable && sel_valid) begin
          state_d = GUARD;
          idx_d   = sel_index;
          guard_d = GUARD_LOAD;
        end
      end
      GUARD: begin
        // A withdrawn request beats the countdown, even on its last cycle.
        if (!req[idx_q]) begin
          state_d = IDLE;
        end else if (guard_q == 8'd0) begin
          state_d = GRANT;
          tmo_d   = '0;
        end else begin
          guard_d = guard_q - 8'd1;
        end
      end
      GRANT: begin
        if (xfer_done || (tmo_q == TMO_LAST)) begin
          state_d = RELEASE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: register inputs derived from the upcoming state so every
  // output lines up with the state it describes.
  always_comb begin
    busy_d       = (state_d != IDLE);
    tune_start_d = (state_q == IDLE) && (state_d == GUARD);
    grant_d      = '0;
    if (state_d == GRANT) grant_d = NUM_NODES'(idx_to_onehot(4'(idx_d)));
    grant_id_d   = ID_W'(idx_d);
    // Done takes precedence over a coincident timeout.
    timeout_d    = (state_q == GRANT) && (state_d == RELEASE) && !xfer_done;
  end

  assign grant         = grant_q;
  assign grant_id      = grant_id_q;
  assign tune_start    = tune_start_q;
  assign busy          = busy_q;
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_photonic_channel_scheduler.sv
module tb_photonic_channel_scheduler;

  localparam int N   = 4;
  localparam int IDW = 16;
  localparam int G   = 2;
  localparam int T   = 8;

  localparam int K_DONE  = 0;
  localparam int K_TMO   = 1;
  localparam int K_ABORT = 2;
  localparam int K_RESET = 3;

  localparam int EV_TUNE = 0;
  localparam int EV_ON   = 1;
  localparam int EV_OFF  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           enable = 1'b0;
  logic [N-1:0]   req = '0;
  logic           xfer_done = 1'b0;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           tune_start;
  logic           busy;
  logic           timeout_pulse;

  always #5 clk = ~clk;

  photonic_channel_scheduler #(
    .NUM_NODES      (N),
    .ID_W           (IDW),
    .GUARD_CYCLES   (G),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .req           (req),
    .xfer_done     (xfer_done),
    .grant         (grant),
    .grant_id      (grant_id),
    .tune_start    (tune_start),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  typedef struct packed {
    int kind;
    int cyc;
    int id;
    int gnt;
    int flag;
    int bsy;
  } ev_t;

  ev_t          exp_q[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;
  int           ptr_m = 0;
  bit           mon_en = 1'b0;
  logic [N-1:0] prev_grant = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input bit ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endfunction

  function automatic string ev_str(input ev_t e);
    return $sformatf("kind=%0d cyc=%0d id=%0d grant=%0d tmo=%0d busy=%0d",
                     e.kind, e.cyc, e.id, e.gnt, e.flag, e.bsy);
  endfunction

  function automatic string ev_name(input int k);
    case (k)
      EV_TUNE: return "tune";
      EV_ON:   return "grant_on";
      default: return "grant_off";
    endcase
  endfunction

  function automatic void push(input int kind, input int c, input int id,
                               input int gnt, input int flag, input int bsy);
    ev_t e;
    e.kind = kind; e.cyc = c; e.id = id; e.gnt = gnt; e.flag = flag; e.bsy = bsy;
    exp_q.push_back(e);
  endfunction

  // Reference arbitration: first requester at or after the pointer.
  function automatic int winner(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      int n;
      n = (ptr_m + i) % N;
      if (m[n]) return n;
    end
    return 0;
  endfunction

  // Monitor: turns DUT output activity into events and scores them.
  always @(negedge clk) begin
    ev_t obs;
    ev_t e;
    bit  have;
    have = 1'b0;
    obs  = '0;
    if (mon_en) begin
      if (tune_start) begin
        obs.kind = EV_TUNE; have = 1'b1;
      end else if (grant != '0 && prev_grant == '0) begin
        obs.kind = EV_ON; have = 1'b1;
      end else if (grant == '0 && prev_grant != '0) begin
        obs.kind = EV_OFF; have = 1'b1;
      end else if (timeout_pulse) begin
        check("stray_timeout", 1'b0, $sformatf("timeout_pulse=1 at cyc %0d, required 0", cyc));
      end
      if (grant != '0 && prev_grant != '0 && grant != prev_grant)
        check("grant_switch", 1'b0, $sformatf("grant %0b -> %0b at cyc %0d", prev_grant, grant, cyc));
      if (have) begin
        obs.cyc  = cyc;
        obs.id   = int'(grant_id);
        obs.gnt  = int'(grant);
        obs.flag = int'(timeout_pulse);
        obs.bsy  = int'(busy);
        if (exp_q.size() == 0) begin
          check("unexpected_event", 1'b0, $sformatf("got %s, required none", ev_str(obs)));
        end else begin
          e = exp_q.pop_front();
          check(ev_name(e.kind), obs == e,
                $sformatf("got %s, required %s", ev_str(obs), ev_str(e)));
        end
      end
      prev_grant = grant;
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    check(name, grant == '0 && grant_id == '0 && !tune_start && !busy && !timeout_pulse,
          $sformatf("grant=%0b id=%0d tune=%0b busy=%0b tmo=%0b, required all 0",
                    grant, grant_id, tune_start, busy, timeout_pulse));
  endtask

  // One arbitration transaction. Called on a negedge at which the DUT will be
  // in IDLE at the next rising edge. kind/d select how the grant ends:
  // DONE after d grant cycles, TMO, ABORT d cycles into GUARD, RESET mid-grant.
  task automatic do_txn(input logic [N-1:0] mask, input int kind, input int d,
                        input int hold, input bit en_drop, input bit noise);
    int k, w, g, off, j;
    if (hold > 0) begin
      enable = 1'b0;
      req    = mask;
      wait_to(cyc + hold);
    end
    k = cyc;
    req = mask;
    enable = 1'b1;
    xfer_done = 1'b0;
    w = winner(mask);
    g = k + 1 + G;
    off = 0;
    j = 0;
    push(EV_TUNE, k + 1, w, 0, 0, 1);
    case (kind)
      K_ABORT: j = k + 1 + d;
      K_DONE: begin
        off = g + d;
        push(EV_ON, g, w, 1 << w, 0, 1);
        push(EV_OFF, off, w, 0, 0, 1);
      end
      K_TMO: begin
        off = g + T;
        push(EV_ON, g, w, 1 << w, 0, 1);
        push(EV_OFF, off, w, 0, 1, 1);
      end
      default: begin
        off = g + 3;
        push(EV_ON, g, w, 1 << w, 0, 1);
        push(EV_OFF, off, 0, 0, 0, 0);
      end
    endcase

    if (en_drop) begin
      wait_to(k + 1);
      enable = 1'b0;
    end
    if (noise && kind != K_ABORT) begin
      wait_to(k + 1);
      xfer_done = 1'b1;
      wait_to(k + 2);
      xfer_done = 1'b0;
    end

    case (kind)
      K_ABORT: begin
        wait_to(j);
        req = '0;
        wait_to(j + 1);
        check("abort_idle", !busy && grant == '0,
              $sformatf("busy=%0b grant=%0b at cyc %0d, required 0/0", busy, grant, cyc));
      end
      K_RESET: begin
        wait_to(g + 2);
        rst = 1'b0;
        wait_to(g + 3);
        rst = 1'b1;
        req = '0;
        enable = 1'b1;
        ptr_m = 0;
        check_zero("reset_mid_grant");
      end
      default: begin
        if (kind == K_DONE) begin
          wait_to(off - 1);
          xfer_done = 1'b1;
        end
        wait_to(off);
        xfer_done = 1'b0;
        req = '0;
        enable = 1'b1;
        ptr_m = (w + 1) % N;
        wait_to(off + 1);
        check("back_to_idle", !busy && grant == '0 && !timeout_pulse,
              $sformatf("busy=%0b grant=%0b tmo=%0b at cyc %0d, required 0/0/0",
                        busy, grant, timeout_pulse, cyc));
      end
    endcase
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b1;
    prev_grant = grant;
    mon_en = 1'b1;

    // Fairness with all nodes requesting: order 0,1,2,3,0.
    for (int i = 0; i < 5; i++) do_txn(4'b1111, K_DONE, 5, 0, 1'b0, 1'b0);
    // Single requester, then a pattern revealing the advanced pointer.
    do_txn(4'b0100, K_DONE, 7, 0, 1'b0, 1'b0);
    do_txn(4'b1011, K_DONE, 3, 0, 1'b1, 1'b1);
    // Timeout, then done colliding with the final timeout cycle.
    do_txn(4'b0010, K_TMO, 0, 0, 1'b0, 1'b1);
    do_txn(4'b0001, K_DONE, T, 0, 1'b0, 1'b0);
    // Abort in GUARD leaves the pointer untouched.
    do_txn(4'b0110, K_ABORT, 1, 0, 1'b0, 1'b0);
    do_txn(4'b0110, K_DONE, 2, 0, 1'b0, 1'b0);
    // Enable held low delays arbitration.
    do_txn(4'b0001, K_DONE, 2, 4, 1'b0, 1'b0);
    // Reset mid-grant; next arbitration starts from node 0.
    do_txn(4'b1100, K_RESET, 0, 0, 1'b0, 1'b0);
    do_txn(4'b1111, K_DONE, 1, 0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] m;
      int r, kind, d, hold;
      bit en_drop, noise;
      m = N'($urandom_range(1, (1 << N) - 1));
      r = $urandom_range(0, 9);
      kind = (r <= 5) ? K_DONE : (r <= 7) ? K_TMO : (r == 8) ? K_ABORT : K_RESET;
      d = (kind == K_DONE) ? $urandom_range(1, T) :
          (kind == K_ABORT) ? $urandom_range(0, G - 1) : 0;
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      en_drop = 1'($urandom_range(0, 1));
      noise = 1'($urandom_range(0, 1));
      do_txn(m, kind, d, hold, en_drop, noise);
    end

    repeat (4) @(negedge clk);
    check("drain", exp_q.size() == 0,
          $sformatf("%0d expected events outstanding, required 0", exp_q.size()));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
